cache_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single request port of the data cache controller between instruction fetch (port 0) and load/store (port 1). It latches one request at a time and holds the cache strobes and address stable until the cache signals completion. It then returns read data and a one-cycle done pulse to the owning requester. It sits between the CPU pipeline front-ends and the cache controller; the controller itself is unchanged.

---
 rtl/cache_port_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// cache_port_arbiter : shares the data-cache request port between instruction
// fetch (port 0) and load/store (port 1); one access in flight at a time.
// Option macro: CACHE_ARB_FIXED_PRI_EN (port 0 always wins a tie).
// Revision: 1.0
// ============================================================================
module cache_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              c_rEn,
  output logic              c_wEn,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_done,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        owner_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef CACHE_ARB_FIXED_PRI_EN
  assign owner_d = m1_req & ~m0_req;
`else
  logic last_served_q;
  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign owner_d = m1_req & (~m0_req | ~last_served_q);
`endif

  assign sel_we    = owner_d ? m1_we    : m0_we;
  assign sel_addr  = owner_d ? m1_addr  : m0_addr;
  assign sel_wdata = owner_d ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRI_EN
      last_served_q <= 1'b1;
`endif
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      c_rEn     <= 1'b0;
      c_wEn     <= 1'b0;
      c_address <= '0;
      c_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            owner_q   <= owner_d;
            c_wEn     <= sel_we;
            c_rEn     <= ~sel_we;
            c_address <= sel_addr;
            c_wdata   <= sel_wdata;
            m0_gnt    <= ~owner_d;
            m1_gnt    <= owner_d;
            busy      <= 1'b1;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          if (c_done) begin
            if (c_rEn) begin
              if (owner_q) m1_rdata <= c_rdata;
              else         m0_rdata <= c_rdata;
            end
            c_rEn   <= 1'b0;
            c_wEn   <= 1'b0;
            m0_done <= ~owner_q;
            m1_done <= owner_q;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          busy    <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRI_EN
          last_served_q <= owner_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// Scoreboard bench for cache_port_arbiter: transaction-level arbitration model,
// cache responder process, and a negedge monitor that checks every cycle.
module tb_cache_port_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        c_rEn, c_wEn, c_done, busy;
  logic [31:0] c_address, c_wdata, c_rdata;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .c_rEn(c_rEn), .c_wEn(c_wEn), .c_address(c_address), .c_wdata(c_wdata),
    .c_done(c_done), .c_rdata(c_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    bit          dbl;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int spur_cnt = 0;
  bit          model_last;
  logic [31:0] model_rd [2];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin (or fixed-priority) winner from the set of requesting ports.
  function automatic bit pick(input logic [1:0] mask);
    if (mask == 2'b01) return 1'b0;
    if (mask == 2'b10) return 1'b1;
`ifdef CACHE_ARB_FIXED_PRI_EN
    return 1'b0;
`else
    return ~model_last;
`endif
  endfunction

  task automatic push_txn(input bit p, input int lat, input logic [31:0] rd, input bit dbl);
    exp_t e;
    rsp_t r;
    e.port  = p;
    e.we    = p ? m1_we : m0_we;
    e.addr  = p ? m1_addr : m0_addr;
    e.wdata = p ? m1_wdata : m0_wdata;
    e.lat   = lat;
    if (!e.we) model_rd[p] = rd;
    e.r0 = model_rd[0];
    e.r1 = model_rd[1];
    exp_q.push_back(e);
    r.lat = lat; r.rd = rd; r.dbl = dbl;
    rsp_q.push_back(r);
    model_last = p;
  endtask

  task automatic set_port(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    if (p) begin m1_we = we; m1_addr = addr; m1_wdata = wd; end
    else   begin m0_we = we; m0_addr = addr; m0_wdata = wd; end
  endtask

  task automatic run_round(input logic [1:0] mask, input int lat_a, input int lat_b,
                           input logic [31:0] rd_a, input logic [31:0] rd_b, input bit dbl);
    int n, got, t;
    bit w;
    n = (mask == 2'b11) ? 2 : 1;
    w = pick(mask);
    push_txn(w, lat_a, rd_a, dbl);
    if (n == 2) push_txn(~w, lat_b, rd_b, dbl);
    m0_req = mask[0];
    m1_req = mask[1];
    got = 0; t = 0;
    while (got < n && t < 400) begin
      @(posedge clk); #1; t++;
      if (m0_gnt) m0_req = 1'b0;
      if (m1_gnt) m1_req = 1'b0;
      if (m0_done || m1_done) got++;
    end
    chk("round_done_count", got, n);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Both ports hold req continuously across n accesses.
  task automatic run_tie(input int n);
    int got, t;
    bit w;
    for (int i = 0; i < n; i++) begin
      w = pick(2'b11);
      push_txn(w, $urandom_range(0, 3), $urandom, 1'b0);
    end
    m0_req = 1'b1;
    m1_req = 1'b1;
    got = 0; t = 0;
    while (got < n && t < 600) begin
      @(posedge clk); #1; t++;
      if (m0_done || m1_done) got++;
    end
    chk("tie_done_count", got, n);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Cache model: answers each access after its scheduled latency.
  initial begin : responder
    rsp_t r;
    bit   abort;
    int   spur_seen;
    spur_seen = 0;
    c_done  = 1'b0;
    c_rdata = '0;
    forever begin
      @(negedge clk);
      c_done = 1'b0;
      if (!rst) begin
        rsp_q.delete();
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        c_done    = 1'b1;
        c_rdata   = $urandom;
      end else if ((c_rEn || c_wEn) && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        abort = 1'b0;
        for (int i = 0; i < r.lat; i++) begin
          @(negedge clk);
          if (!rst) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          c_done  = 1'b1;
          c_rdata = r.rd;
          @(negedge clk);
          c_done  = r.dbl;
          c_rdata = $urandom;
        end else begin
          rsp_q.delete();
        end
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   in_acc;
    int   gcyc;
    in_acc = 1'b0;
    gcyc   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_acc = 1'b0;
        exp_q.delete();
      end else if (m0_gnt || m1_gnt) begin
        if (in_acc || exp_q.size() == 0 || (m0_gnt && m1_gnt)) begin
          chk("unexpected_gnt", {m1_gnt, m0_gnt}, 0);
        end else begin
          cur    = exp_q.pop_front();
          in_acc = 1'b1;
          gcyc   = cyc;
          chk("gnt_port", m1_gnt, cur.port);
          chk("gnt_wEn", c_wEn, cur.we);
          chk("gnt_rEn", c_rEn, !cur.we);
          chk("gnt_addr", c_address, cur.addr);
          chk("gnt_wdata", c_wdata, cur.wdata);
          chk("gnt_busy", busy, 1);
        end
      end else if (m0_done || m1_done) begin
        if (!in_acc || (m0_done && m1_done)) begin
          chk("unexpected_done", {m1_done, m0_done}, 0);
        end else begin
          chk("done_port", m1_done, cur.port);
          chk("done_cycle", cyc, gcyc + cur.lat + 1);
          chk("m0_rdata", m0_rdata, cur.r0);
          chk("m1_rdata", m1_rdata, cur.r1);
          chk("done_strobes", {c_rEn, c_wEn}, 0);
          chk("done_busy", busy, 1);
          in_acc = 1'b0;
        end
      end else if (in_acc) begin
        chk("hold_strobes", {c_rEn, c_wEn}, {!cur.we, cur.we});
        chk("hold_addr", c_address, cur.addr);
        chk("hold_wdata", c_wdata, cur.wdata);
        chk("hold_busy", busy, 1);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_strobes", {c_rEn, c_wEn}, 0);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int t;
    rst = 1'b0;
    m0_req = 0; m1_req = 0;
    m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    model_last = 1'b1;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_outs", {m0_gnt, m1_gnt, m0_done, m1_done, c_rEn, c_wEn, busy}, 0);
    chk("reset_data_outs", |{m0_rdata, m1_rdata, c_address, c_wdata}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single read on port 0, cache answers three cycles after strobe rise.
    set_port(0, 1'b0, 32'h0000_0010, 32'h0);
    run_round(2'b01, 3, 0, 32'hDEAD_BEEF, 32'h0, 1'b1);

    // Port 1 write with a long cache latency.
    set_port(1, 1'b1, 32'h0000_0024, 32'h1234_5678);
    run_round(2'b10, 10, 0, 32'hCAFE_F00D, 32'h0, 1'b0);

    // Spurious completion while idle.
    @(posedge clk); #1;
    spur_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_done", {m0_done, m1_done}, 0);

    // Continuous tie.
    set_port(0, 1'b0, 32'h0000_1000, 32'h0);
    set_port(1, 1'b0, 32'h0000_2000, 32'h0);
    run_tie(4);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      set_port(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      set_port(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      run_round(2'($urandom_range(1, 3)), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset two cycles into a long access.
    set_port(0, 1'b0, 32'h0000_0040, 32'h0);
    push_txn(0, 20, 32'h5555_AAAA, 1'b0);
    m0_req = 1'b1;
    t = 0;
    while (!m0_gnt && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("rst_test_gnt", m0_gnt, 1);
    m0_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("midrst_ctrl_outs", {m0_gnt, m1_gnt, m0_done, m1_done, c_rEn, c_wEn, busy}, 0);
    chk("midrst_data_outs", |{m0_rdata, m1_rdata, c_address, c_wdata}, 0);
    model_last  = 1'b1;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_done", {m0_done, m1_done, busy}, 0);

    // Fresh port 0 read and the first tie after reset.
    set_port(0, 1'b0, 32'h0000_0080, 32'h0);
    set_port(1, 1'b1, 32'h0000_0084, 32'hA5A5_5A5A);
    run_round(2'b11, 2, 1, 32'h0BAD_F00D, 32'h0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
